sqrt_share_arbiter: RTL and testbench
=====================================

// Module: sqrt_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one iterative sqrt engine (NBITS-in, MBITS-out,
//  start/done handshake, done = ~busy) among NREQ magnitude paths (per-pad |X|^2 -> |X|).
//  Captures one requester's operand, pulses the engine's start, waits for completion and
//  returns the root tagged with the requester id. Includes a watchdog on the engine.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IDW      2   id width, = ceil(log2(NREQ))
//  NBITS    28  operand width (engine NBITS)
//  MBITS    14  result width, = (NBITS+1)/2
//  TIMEOUT  31  max cycles in ARM+WAIT before watchdog fires (> MBITS+1)
// PORTS
//  clock_27mhz  in   1           system clock, all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  req          in   NREQ        level request, held until matching ack
//  req_data     in   NREQ*NBITS  operands; requester i at [i*NBITS +: NBITS]
//  ack          out  NREQ        one-hot 1-cycle pulse: operand captured
//  rsp_valid    out  NREQ        one-hot 1-cycle pulse: result ready for that requester
//  rsp_data     out  MBITS       result, valid while any rsp_valid bit high
//  rsp_id       out  IDW         id of requester in rsp_valid
//  busy         out  1           high whenever state != IDLE
//  timeout_err  out  1           sticky watchdog flag
//  err_clr      in   1           sync clear of timeout_err
//  sq_start     out  1           to engine: start pulse
//  sq_data      out  NBITS       to engine: operand, stable ISSUE..WAIT
//  sq_answer    in   MBITS       from engine: root
//  sq_done      in   1           from engine: high when idle/finished
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE; ack, rsp_valid, rsp_data, rsp_id, sq_data,
//   timeout_err, watchdog counter = 0; rr pointer = NREQ-1 (requester 0 wins first).
//   Reset mid-operation abandons the job; no rsp_valid for it.
//  States: IDLE -> ISSUE -> ARM -> WAIT -> IDLE.
//  IDLE: if |req and sq_done: pick first set req scanning ptr+1, ptr+2, ... (mod NREQ);
//   on edge: ack[i]<=1, sq_data<=req_data[i], id<=i, ptr<=i, ->ISSUE. sq_done low: no grant.
//  ISSUE: sq_start=1 (decode of state, exactly one cycle); ->ARM.
//  ARM: one cycle, sq_done ignored (engine busy flag not yet guaranteed); ->WAIT.
//  WAIT: on sq_done=1: rsp_data<=sq_answer, rsp_id<=id, rsp_valid[id]<=1, ->IDLE.
//  Watchdog: counter cleared in ISSUE, increments in ARM/WAIT; when it reaches TIMEOUT
//   without done: rsp_valid[id]<=1, rsp_data<={MBITS{1'b1}}, timeout_err<=1, ->IDLE.
//  timeout_err: set by watchdog; cleared by err_clr; set wins if same cycle.
//  ack, rsp_valid are registered 1-cycle pulses; rsp_data/rsp_id hold until next response.
//  Latency (MBITS=14): req seen cycle 0 -> ack cycle 1 -> sq_start cycle 1 ->
//   rsp_valid cycle 17 (MBITS+3). IDLE in cycle 17; next ack earliest cycle 18.
//  Requester keeping req high after ack re-enters arbitration; rr ensures it waits
//   behind every other pending requester. req sampled only in IDLE; req_data must be
//   stable in the IDLE cycle it is granted.
//  Max throughput: one operation per MBITS+3 cycles.
// TESTING
//  1. req[0], data 1_000_000 -> ack[0] cycle 1, rsp_valid[0] cycle 17, rsp_data 1000, rsp_id 0.
//  2. req[3:0] all at once, data {144, 2^28-1, 1, 0} for ids 3..0 -> served 0,1,2,3,
//     results 0,1,16383,12, rsp_valid 17 cycles apart.
//  3. req[0] held high permanently, req[2] pulsed until ack -> grants alternate 0,2,0,...;
//     req[0] never granted twice while req[2] pending.
//  4. reset_n low during WAIT -> all outputs 0 at once, no rsp_valid; after release,
//     req[1]&req[0] -> ack[0] first.
//  5. engine model holds sq_done low after start -> rsp_valid[id] after TIMEOUT cycles,
//     rsp_data 0x3FFF, timeout_err=1 until err_clr pulse, then 0.
//  6. sq_done held low in IDLE with req[1] high -> no ack; sq_done high -> ack[1] next cycle.

Source files
------------

// File: rtl/sqrt_share_arbiter.sv
// Round-robin sequencer sharing one iterative sqrt engine among NREQ
// magnitude paths, with a watchdog on the engine handshake.
module sqrt_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int NBITS   = 28,
  parameter int MBITS   = 14,
  parameter int TIMEOUT = 31
) (
  input  logic                  clock_27mhz,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [MBITS-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr,
  output logic                  sq_start,
  output logic [NBITS-1:0]      sq_data,
  input  logic [MBITS-1:0]      sq_answer,
  input  logic                  sq_done
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [WDW-1:0]   wd;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;

  // first pending requester after the last one served
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
  end

  assign sq_start = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ack         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      sq_data     <= '0;
      timeout_err <= 1'b0;
      wd          <= '0;
      ptr         <= IDW'(NREQ - 1);
      id          <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      if (err_clr)
        timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_vld && sq_done) begin
            ack[gnt_id] <= 1'b1;
            sq_data     <= req_data[int'(gnt_id)*NBITS +: NBITS];
            id          <= gnt_id;
            ptr         <= gnt_id;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_ARM;
        end
        // engine busy flag is not yet trustworthy here
        S_ARM: begin
          wd    <= wd + WDW'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (sq_done) begin
            rsp_data      <= sq_answer;
            rsp_id        <= id;
            rsp_valid[id] <= 1'b1;
            state         <= S_IDLE;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            rsp_data      <= '1;
            rsp_id        <= id;
            rsp_valid[id] <= 1'b1;
            timeout_err   <= 1'b1;
            state         <= S_IDLE;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Bench for sqrt_share_arbiter: transaction-level model plus directed
// scenarios, then randomized traffic against a variable-latency engine.
`timescale 1ns/1ps
module tb_sqrt_share_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int NBITS   = 28;
  localparam int MBITS   = 14;
  localparam int TIMEOUT = 31;

  logic                  clock_27mhz = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*NBITS-1:0] req_data = '0;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       rsp_valid;
  logic [MBITS-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic                  timeout_err;
  logic                  err_clr = 1'b0;
  logic                  sq_start;
  logic [NBITS-1:0]      sq_data;
  logic [MBITS-1:0]      sq_answer;
  logic                  sq_done;

  sqrt_share_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .NBITS(NBITS), .MBITS(MBITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_27mhz(clock_27mhz), .reset_n(reset_n),
    .req(req), .req_data(req_data), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .sq_start(sq_start), .sq_data(sq_data),
    .sq_answer(sq_answer), .sq_done(sq_done)
  );

  always #18 clock_27mhz = ~clock_27mhz;

  function automatic longint isqrt(longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // engine stand-in: busy for a set latency after start
  int eng_cnt;
  bit eng_rand = 1'b0;
  bit eng_stuck = 1'b0;
  bit eng_hold = 1'b0;
  int eng_lat = 14;

  always @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      eng_cnt   <= 0;
      sq_answer <= '0;
    end else if (sq_start) begin
      eng_cnt   <= eng_rand ? int'($urandom_range(1, 34)) : eng_lat;
      sq_answer <= MBITS'(isqrt(longint'(sq_data)));
    end else if (eng_cnt != 0 && !eng_stuck) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign sq_done = !eng_hold && (eng_cnt == 0);

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state and expected outputs for the current cycle
  bit               m_busy;
  int               m_ptr;
  int               m_id;
  int               m_k;
  longint           m_root;
  logic [NREQ-1:0]  e_ack, e_rv;
  logic [MBITS-1:0] e_rd;
  logic [IDW-1:0]   e_rid;
  logic [NBITS-1:0] e_sqd;
  logic             e_busy, e_start, e_err;

  int ack_id_q[$], ack_cyc_q[$];
  int rsp_id_q[$], rsp_dat_q[$], rsp_cyc_q[$];
  bit [NREQ-1:0] keep = '0;
  bit rnd_on = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic int oh(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NBITS-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return NBITS'($urandom_range(0, 300));
      default: return NBITS'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = NREQ - 1;
    m_id    = 0;
    m_k     = 0;
    m_root  = 0;
    e_ack   = '0;
    e_rv    = '0;
    e_rd    = '0;
    e_rid   = '0;
    e_sqd   = '0;
    e_busy  = 1'b0;
    e_start = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic respond(logic [MBITS-1:0] d, bit fire);
    e_rv[m_id] = 1'b1;
    e_rd       = d;
    e_rid      = IDW'(m_id);
    m_busy     = 1'b0;
    if (fire) e_err = 1'b1;
  endtask

  // compare this cycle, then derive what the next cycle must show
  task automatic model_step();
    int w;
    bit fire;
    chk("ack", ack, e_ack);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, e_rd);
    chk("rsp_id", rsp_id, e_rid);
    chk("sq_data", sq_data, e_sqd);
    chk("busy", busy, e_busy);
    chk("sq_start", sq_start, e_start);
    chk("timeout_err", timeout_err, e_err);
    e_ack   = '0;
    e_rv    = '0;
    e_start = 1'b0;
    fire    = 1'b0;
    if (err_clr) e_err = 1'b0;
    if (!m_busy) begin
      if (|req && sq_done) begin
        w = -1;
        for (int s = 1; s <= NREQ; s++)
          if (w < 0 && req[(m_ptr + s) % NREQ]) w = (m_ptr + s) % NREQ;
        e_ack[w] = 1'b1;
        e_sqd    = req_data[w*NBITS +: NBITS];
        m_root   = isqrt(longint'(e_sqd));
        m_id     = w;
        m_ptr    = w;
        m_busy   = 1'b1;
        m_k      = 0;
        e_start  = 1'b1;
      end
    end else if (m_k >= 2 && sq_done) begin
      respond(MBITS'(m_root), 1'b0);
    end else if (m_k == TIMEOUT) begin
      fire = 1'b1;
      respond('1, 1'b1);
    end else begin
      m_k++;
    end
    if (fire) e_err = 1'b1;
    e_busy = m_busy;
  endtask

  task automatic tick();
    @(negedge clock_27mhz);
    if (!reset_n) model_reset();
    else model_step();
    @(posedge clock_27mhz);
    #1;
    cyc++;
    if (|ack) begin
      ack_id_q.push_back(oh(ack));
      ack_cyc_q.push_back(cyc);
    end
    if (|rsp_valid) begin
      rsp_id_q.push_back(oh(rsp_valid));
      rsp_dat_q.push_back(int'(rsp_data));
      rsp_cyc_q.push_back(cyc);
    end
    err_clr = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (ack[i] && !keep[i]) req[i] = 1'b0;
    if (rnd_on) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_data[i*NBITS +: NBITS] = rnd_op();
          req[i] = 1'b1;
        end
      err_clr = ($urandom_range(0, 49) == 0);
    end
  endtask

  task automatic do_reset(int n);
    reset_n = 1'b0;
    req     = '0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_rsp(int target, int budget, string nm);
    int t = 0;
    while (rsp_id_q.size() < target && t < budget) begin
      tick();
      t++;
    end
    if (rsp_id_q.size() < target) fail_bound(nm);
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    if (busy) fail_bound("idle");
    tick();
  endtask

  initial begin
    int t0, ab, rb, t;
    int exp2[4];
    exp2 = '{0, 1, 16383, 12};
    chk("model_isqrt_1e6", isqrt(1000000), 1000);
    chk("model_isqrt_max", isqrt(longint'(2**28 - 1)), 16383);
    do_reset(3);

    // single request latency and result
    req_data[0 +: NBITS] = 28'd1000000;
    req[0] = 1'b1;
    t0 = cyc;
    wait_rsp(rsp_id_q.size() + 1, 40, "t1_rsp");
    chk("t1_ack_cycle", ack_cyc_q[$], t0 + 1);
    chk("t1_rsp_cycle", rsp_cyc_q[$], t0 + 17);
    chk("t1_rsp_data", rsp_dat_q[$], 1000);
    chk("t1_rsp_id", rsp_id_q[$], 0);
    wait_idle(40);

    // all four at once from reset pointer
    do_reset(2);
    req_data[0*NBITS +: NBITS] = 28'd0;
    req_data[1*NBITS +: NBITS] = 28'd1;
    req_data[2*NBITS +: NBITS] = 28'hFFFFFFF;
    req_data[3*NBITS +: NBITS] = 28'd144;
    ab = ack_id_q.size();
    rb = rsp_id_q.size();
    req = 4'hF;
    wait_rsp(rb + 4, 100, "t2_rsp");
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", ack_id_q[ab + k], k);
      chk("t2_data", rsp_dat_q[rb + k], exp2[k]);
      if (k > 0) chk("t2_spacing", rsp_cyc_q[rb + k] - rsp_cyc_q[rb + k - 1], 17);
    end
    wait_idle(40);

    // sticky requester 0 alternates with re-pulsed requester 2
    ab = ack_id_q.size();
    keep[0] = 1'b1;
    req[0] = 1'b1;
    req[2] = 1'b1;
    t = 0;
    while (ack_id_q.size() < ab + 4 && t < 120) begin
      tick();
      t++;
      if (!req[2]) req[2] = 1'b1;
    end
    if (ack_id_q.size() < ab + 4) fail_bound("t3_grants");
    chk("t3_g0", ack_id_q[ab + 0], 0);
    chk("t3_g1", ack_id_q[ab + 1], 2);
    chk("t3_g2", ack_id_q[ab + 2], 0);
    chk("t3_g3", ack_id_q[ab + 3], 2);
    keep = '0;
    req = '0;
    wait_idle(40);

    // no grant while the engine reports busy
    eng_hold = 1'b1;
    req[1] = 1'b1;
    ab = ack_id_q.size();
    repeat (5) tick();
    chk("t6_no_ack", ack_id_q.size(), ab);
    eng_hold = 1'b0;
    tick();
    chk("t6_ack", ack, 4'b0010);
    wait_idle(40);

    // stuck engine trips the watchdog
    eng_stuck = 1'b1;
    req_data[2*NBITS +: NBITS] = 28'd144;
    req[2] = 1'b1;
    rb = rsp_id_q.size();
    wait_rsp(rb + 1, 60, "t5_rsp");
    chk("t5_data", rsp_dat_q[$], 16'h3FFF);
    chk("t5_id", rsp_id_q[$], 2);
    chk("t5_delay", rsp_cyc_q[$] - ack_cyc_q[$], TIMEOUT + 1);
    chk("t5_err_set", timeout_err, 1'b1);
    eng_stuck = 1'b0;
    repeat (20) tick();
    chk("t5_err_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    chk("t5_err_clr", timeout_err, 1'b0);

    // reset mid-job
    req_data[0 +: NBITS] = 28'd49;
    req[0] = 1'b1;
    repeat (6) tick();
    chk("t4_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("t4_ctl_zero", {ack, rsp_valid, rsp_id, busy, timeout_err, sq_start}, '0);
    chk("t4_rsp_data_zero", rsp_data, '0);
    chk("t4_sq_data_zero", sq_data, '0);
    rb = rsp_id_q.size();
    repeat (3) tick();
    reset_n = 1'b1;
    req = 4'b0011;
    ab = ack_id_q.size();
    t = 0;
    while (ack_id_q.size() == ab && t < 10) begin
      tick();
      t++;
    end
    chk("t4_first", ack_id_q[ab], 0);
    chk("t4_no_rsp", rsp_id_q.size(), rb);
    wait_rsp(rb + 2, 80, "t4_rsp");
    wait_idle(40);

    // randomized traffic, variable engine latency, occasional reset
    eng_rand = 1'b1;
    rnd_on = 1'b1;
    for (int p = 0; p < 2; p++) begin
      keep = (p == 1) ? 4'b0100 : 4'b0000;
      repeat (2000) begin
        tick();
        if ($urandom_range(0, 1499) == 0) do_reset(2);
      end
    end
    rnd_on = 1'b0;
    keep = '0;
    req = '0;
    wait_idle(60);
    eng_rand = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
